// File: rtl/fft_frame_gen.sv
// Purpose: generates framed beat streams (sop/eop/index) for an FFT core; frame length, gap and count are latched at start.
// Latency: the first beat is valid one cycle after an accepted start; every output is registered.
// Backpressure: sink_ready low freezes the current beat (valid/sop/eop/idx held); ready latency is 0.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start, stop            begin run (IDLE only) / graceful stop after the current frame
//   cfg_len, cfg_gap       beats per frame / idle cycles between frames
//   cfg_frames             frames per run, 0 = continuous
//   sink_ready             downstream ready
//   sink_valid/sop/eop/idx beat stream
//   frame_cnt              frames completed in the current run
//   busy, done             not-idle flag / one-cycle end-of-run pulse
module fft_frame_gen #(
  parameter int LEN_W = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [LEN_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic             sink_ready,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  output logic [LEN_W-1:0] sink_idx,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_DONE} state_t;

  state_t           state_q, state_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] gap_q, gap_n;
  logic [LEN_W-1:0] gcnt_q, gcnt_n;
  logic [LEN_W-1:0] idx_n;
  logic [CNT_W-1:0] frames_q, frames_n;
  logic [CNT_W-1:0] fcnt_n, fcnt_inc;
  logic             stop_seen_q, stop_seen_n;
  logic             fire, run_end;
  logic             valid_n, sop_n, eop_n, busy_n, done_n;

  // sink_valid is only ever high in ACTIVE, so fire implies ACTIVE.
  assign fire     = sink_valid & sink_ready;
  assign fcnt_inc = frame_cnt + CNT_W'(1);
  // A stop arriving on the eop cycle itself still counts as seen within this frame.
  assign run_end  = ((frames_q != '0) && (fcnt_inc == frames_q)) || stop_seen_q || stop;

  // State and datapath register; outputs are registered copies of their next values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      frames_q    <= '0;
      gcnt_q      <= '0;
      stop_seen_q <= 1'b0;
      sink_idx    <= '0;
      frame_cnt   <= '0;
      sink_valid  <= 1'b0;
      sink_sop    <= 1'b0;
      sink_eop    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      len_q       <= len_n;
      gap_q       <= gap_n;
      frames_q    <= frames_n;
      gcnt_q      <= gcnt_n;
      stop_seen_q <= stop_seen_n;
      sink_idx    <= idx_n;
      frame_cnt   <= fcnt_n;
      sink_valid  <= valid_n;
      sink_sop    <= sop_n;
      sink_eop    <= eop_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_n     = state_q;
    len_n       = len_q;
    gap_n       = gap_q;
    frames_n    = frames_q;
    gcnt_n      = gcnt_q;
    stop_seen_n = stop_seen_q;
    idx_n       = sink_idx;
    fcnt_n      = frame_cnt;
    case (state_q)
      S_IDLE: begin
        if (start && (cfg_len != '0)) begin
          state_n     = S_ACTIVE;
          len_n       = cfg_len;
          gap_n       = cfg_gap;
          frames_n    = cfg_frames;
          fcnt_n      = '0;
          idx_n       = '0;
          stop_seen_n = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (stop) stop_seen_n = 1'b1;
        if (fire) begin
          if (sink_eop) begin
            fcnt_n = fcnt_inc;
            idx_n  = '0;
            if (run_end) begin
              state_n = S_DONE;
            end else if (gap_q != '0) begin
              state_n = S_GAP;
              gcnt_n  = gap_q;
            end
          end else begin
            idx_n = sink_idx + LEN_W'(1);
          end
        end
      end
      S_GAP: begin
        // gcnt counts the remaining idle cycles including this one.
        if (stop) begin
          state_n = S_DONE;
        end else if (gcnt_q == LEN_W'(1)) begin
          state_n = S_ACTIVE;
        end else begin
          gcnt_n = gcnt_q - LEN_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with state_q.
  always_comb begin
    valid_n = (state_n == S_ACTIVE);
    sop_n   = valid_n && (idx_n == '0);
    eop_n   = valid_n && (idx_n == (len_n - LEN_W'(1)));
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_DONE);
  end

endmodule

// File: tb/tb_fft_frame_gen.sv
// Directed bench for fft_frame_gen: inputs change 1 time unit after the rising edge,
// outputs are sampled at the same point (i.e. reflecting that edge).
module tb_fft_frame_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, sink_ready;
  logic [11:0] cfg_len, cfg_gap;
  logic [15:0] cfg_frames;
  logic        sink_valid, sink_sop, sink_eop, busy, done;
  logic [11:0] sink_idx;
  logic [15:0] frame_cnt;

  int passed = 0;
  int total  = 0;

  fft_frame_gen #(.LEN_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_frames(cfg_frames),
    .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_idx(sink_idx), .frame_cnt(frame_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic start_run(input int len, input int gap, input int frames);
    cfg_len = 12'(len); cfg_gap = 12'(gap); cfg_frames = 16'(frames);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, acc, eops, hold, eidx, beats, c;
    logic seen_done, sent;

    rst = 1'b1; start = 1'b1; stop = 1'b0; sink_ready = 1'b1;
    cfg_len = 12'd4; cfg_gap = 12'd0; cfg_frames = 16'd1;
    tick();
    // reset state, start together with rst ignored
    check("rst_valid", sink_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_done", done, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("start_with_rst_ignored", busy, 0);

    // start with cfg_len=0 ignored
    start_run(0, 0, 1);
    check("len0_busy", busy, 0);
    check("len0_valid", sink_valid, 0);

    // 512-beat single frame
    start_run(512, 0, 1);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (sink_valid !== 1'b1 || sink_idx !== 12'(i) || sink_sop !== (i == 0) ||
          sink_eop !== (i == 511) || busy !== 1'b1) bad++;
      tick();
    end
    check("len512_beats", bad, 0);
    check("len512_done", done, 1);
    check("len512_done_valid", sink_valid, 0);
    check("len512_fcnt", frame_cnt, 1);
    tick();
    check("len512_idle_done", done, 0);
    check("len512_idle_busy", busy, 0);
    check("len512_fcnt_hold", frame_cnt, 1);

    // 4 valid / 3 idle pattern, cfg changes and start pulse mid-run ignored
    start_run(4, 3, 3);
    cfg_len = 12'd9; cfg_gap = 12'd0; cfg_frames = 16'd0;
    bad = 0;
    for (int k = 0; k < 18; k++) begin
      int pos;
      logic ev;
      pos = k % 7;
      ev  = (pos < 4);
      start = (k == 2);
      if (sink_valid !== ev || sink_idx !== 12'(ev ? pos : 0) || busy !== 1'b1 ||
          sink_sop !== (ev && pos == 0) || sink_eop !== (ev && pos == 3)) bad++;
      tick();
    end
    start = 1'b0;
    check("gap_pattern", bad, 0);
    check("gap_done", done, 1);
    check("gap_fcnt", frame_cnt, 3);
    tick();

    // backpressure at idx 2 for 5 cycles
    start_run(8, 0, 1);
    acc = 0; eops = 0; hold = 0; bad = 0; eidx = 0;
    for (int k = 0; k < 30; k++) begin
      if (sink_valid !== 1'b1) break;
      sink_ready = !(sink_idx == 12'd2 && hold < 5);
      if (!sink_ready) begin
        hold++;
        if (sink_idx !== 12'd2 || sink_eop !== 1'b0 || sink_sop !== 1'b0) bad++;
      end else begin
        acc++;
        if (sink_idx !== 12'(eidx)) bad++;
        if (sink_eop !== (eidx == 7)) bad++;
        if (sink_eop === 1'b1) eops++;
        eidx++;
      end
      tick();
    end
    sink_ready = 1'b1;
    check("bp_hold_cycles", hold, 5);
    check("bp_seq", bad, 0);
    check("bp_accepted", acc, 8);
    check("bp_eops", eops, 1);
    check("bp_done", done, 1);
    tick();

    // cfg_len=1: sop=eop each beat
    start_run(1, 0, 4);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (sink_valid !== 1'b1 || sink_sop !== 1'b1 || sink_eop !== 1'b1 || sink_idx !== 12'd0) bad++;
      tick();
    end
    check("len1_beats", bad, 0);
    check("len1_done", done, 1);
    check("len1_fcnt", frame_cnt, 4);
    tick();

    // continuous run stopped mid third frame
    start_run(16, 0, 0);
    beats = 0; bad = 0; seen_done = 1'b0; sent = 1'b0; c = 0;
    while (c < 200 && !seen_done) begin
      stop = 1'b0;
      if (done === 1'b1) seen_done = 1'b1;
      else begin
        if (sink_valid === 1'b1) begin
          if (sink_idx !== 12'(beats % 16)) bad++;
          beats++;
        end
        if (sink_valid === 1'b1 && frame_cnt == 16'd2 && sink_idx == 12'd5 && !sent) begin
          stop = 1'b1; sent = 1'b1;
        end
        tick();
      end
      c++;
    end
    stop = 1'b0;
    check("stop_done_seen", seen_done, 1);
    check("stop_beats", beats, 48);
    check("stop_idx_seq", bad, 0);
    check("stop_fcnt", frame_cnt, 3);
    tick();

    // stop during GAP ends run without another frame
    start_run(2, 5, 0);
    tick();
    tick();
    check("gapstop_in_gap", {sink_valid, busy}, 2'b01);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("gapstop_done", done, 1);
    check("gapstop_fcnt", frame_cnt, 1);
    tick();
    check("gapstop_idle", busy, 0);

    // reset mid-frame then restart
    start_run(512, 0, 1);
    for (int i = 0; i < 100; i++) tick();
    check("rstmid_idx", sink_idx, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_outs", {sink_valid, sink_sop, sink_eop, busy, done}, 0);
    check("rstmid_idx0", sink_idx, 0);
    check("rstmid_fcnt", frame_cnt, 0);
    start_run(4, 0, 1);
    check("restart_beat", {sink_valid, sink_sop, sink_eop}, 3'b110);
    check("restart_idx", sink_idx, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fft_frame_gen.md
FFT_FRAME_GEN -- requirements
Module: fft_frame_gen

Interface
REQ-001 Parameter LEN_W, default 12: width of frame-length, index and gap fields; max frame 2^LEN_W-1 beats.
REQ-002 Parameter CNT_W, default 16: width of frame-count fields.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 stop  in  1  graceful stop request; current frame completes, then run ends.
REQ-007 cfg_len  in  LEN_W  beats per frame; latched on accepted start.
REQ-008 cfg_gap  in  LEN_W  idle cycles between frames; latched on accepted start.
REQ-009 cfg_frames  in  CNT_W  frames per run, 0 = continuous; latched on accepted start.
REQ-010 sink_ready  in  1  downstream ready; beat transfers when sink_valid & sink_ready.
REQ-011 sink_valid  out  1  beat valid.
REQ-012 sink_sop  out  1  first beat of frame; qualified by sink_valid.
REQ-013 sink_eop  out  1  last beat of frame; qualified by sink_valid.
REQ-014 sink_idx  out  LEN_W  beat index within frame, 0..cfg_len-1.
REQ-015 frame_cnt  out  CNT_W  frames completed in current run.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at run end.

Function
REQ-018 States SHALL be IDLE, ACTIVE, GAP, DONE; all outputs registered.
REQ-019 IDLE: start=1 and cfg_len!=0 -> latch cfg, clear frame_cnt, go ACTIVE; sink_valid=1, sink_sop=1, sink_idx=0 on the next cycle (latency 1).
REQ-020 start with cfg_len=0 SHALL be ignored (stay IDLE, no outputs change).
REQ-021 start outside IDLE SHALL be ignored; cfg inputs outside accepted start SHALL be ignored.
REQ-022 ACTIVE: sink_valid=1 continuously; sink_sop=(idx==0), sink_eop=(idx==len-1).
REQ-023 sink_ready=0 with sink_valid=1: sink_valid, sink_sop, sink_eop, sink_idx SHALL hold unchanged (ready latency 0).
REQ-024 Accepted non-eop beat: idx increments by 1 next cycle.
REQ-025 Accepted eop beat: frame_cnt increments (wraps at 2^CNT_W-1 to 0 in continuous mode); idx returns to 0.
REQ-026 After eop: if run ends -> DONE; else if gap!=0 -> GAP with sink_valid=0 for exactly gap cycles, then ACTIVE with sop; else next cycle is sop beat (back-to-back frames, no bubble).
REQ-027 Run ends at accepted eop when frame_cnt+1==cfg_frames (cfg_frames!=0), or when stop has been seen since the current frame's sop or during preceding GAP.
REQ-028 stop in IDLE or DONE SHALL be ignored; stop in GAP SHALL go DONE at end of current GAP cycle, no further frame.
REQ-029 cfg_len=1: sink_sop and sink_eop asserted on the same beat.
REQ-030 DONE: lasts one cycle, done=1, sink_valid=0; then IDLE; frame_cnt holds final value until next accepted start.
REQ-031 sink_sop/sink_eop SHALL be 0 whenever sink_valid=0.

Reset
REQ-032 rst=1 at any clock edge, including mid-frame or mid-GAP: next cycle state=IDLE, sink_valid=0, sink_sop=0, sink_eop=0, sink_idx=0, frame_cnt=0, busy=0, done=0, latched cfg=0.
REQ-033 start asserted together with rst SHALL be ignored.

Verification
REQ-034 cfg_len=512, cfg_gap=0, cfg_frames=1, ready=1, start -> valid 512 cycles from cycle+1, sop at idx 0, eop at idx 511, done pulse next cycle, frame_cnt=1.
REQ-035 cfg_len=4, cfg_gap=3, cfg_frames=3 -> pattern 4 valid/3 idle/4 valid/3 idle/4 valid, then done; frame_cnt=3.
REQ-036 cfg_len=8, ready low on idx 2 for 5 cycles -> idx stays 2 with valid held, total 8 accepted beats, eop only on idx 7.
REQ-037 cfg_len=1, cfg_gap=0, cfg_frames=4 -> 4 consecutive beats each with sop=eop=1, frame_cnt=4.
REQ-038 cfg_frames=0, cfg_len=16, stop pulse at idx 5 of frame 2 -> frame 2 completes (eop at idx 15), done next cycle, frame_cnt=3.
REQ-039 rst asserted at idx 100 of cfg_len=512 run -> next cycle all outputs 0, IDLE; subsequent start restarts at idx 0 with sop.
